// File: rtl/shreg_seq_if.sv
// rtl/shreg_seq_if.sv - control/data bundle for the sequenced shift register
// Optional rot input present only when SHREG_ROTATE_EN is defined.
interface shreg_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic [WIDTH-1:0] D;
    logic             sclr;
    logic             ld;
    logic             E;
    logic             dir;
    logic             w;
    logic             start;
    logic [CNT_W-1:0] cnt;
`ifdef SHREG_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] Q;
    logic             so;
    logic             busy;
    logic             done;

    modport master (
`ifdef SHREG_ROTATE_EN
        output rot,
`endif
        output D, sclr, ld, E, dir, w, start, cnt,
        input  Q, so, busy, done
    );

    modport slave (
`ifdef SHREG_ROTATE_EN
        input  rot,
`endif
        input  D, sclr, ld, E, dir, w, start, cnt,
        output Q, so, busy, done
    );
endinterface

// File: rtl/shreg_seq.sv
// rtl/shreg_seq.sv - shift register with load/clear and counted multi-shift sequences
// Define SHREG_ROTATE_EN to add the rot input (shift-out bit re-inserted instead of w).
module shreg_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    shreg_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic             so_r, so_nx;
    logic [CNT_W-1:0] rem_r, rem_nx;
    logic             dir_r, dir_nx;

    logic             shift_dir;
    logic             do_shift;
    logic             ins_left, ins_right;
    logic [WIDTH-1:0] q_left, q_right;

    // Inserted bit per direction: the live serial input, or the bit leaving the other end.
`ifdef SHREG_ROTATE_EN
    assign ins_left  = bus.rot ? q_r[WIDTH-1] : bus.w;
    assign ins_right = bus.rot ? q_r[0]       : bus.w;
`else
    assign ins_left  = bus.w;
    assign ins_right = bus.w;
`endif

    assign q_left  = {q_r[WIDTH-2:0], ins_left};
    assign q_right = {ins_right, q_r[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q_r   <= '0;
            so_r  <= 1'b0;
            rem_r <= '0;
            dir_r <= 1'b0;
        end else begin
            state <= state_nx;
            q_r   <= q_nx;
            so_r  <= so_nx;
            rem_r <= rem_nx;
            dir_r <= dir_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rem_nx    = rem_r;
        dir_nx    = dir_r;
        do_shift  = 1'b0;
        shift_dir = dir_r;

        if (bus.sclr && bus.E) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld && bus.E) begin
                        state_nx = IDLE;
                    end else if (bus.start) begin
                        dir_nx   = bus.dir;
                        rem_nx   = bus.cnt;
                        state_nx = (bus.cnt == '0) ? FIN : RUN;
                    end else if (bus.E) begin
                        do_shift  = 1'b1;
                        shift_dir = bus.dir;
                    end
                end
                RUN: begin
                    if (bus.E) begin
                        do_shift = 1'b1;
                        rem_nx   = rem_r - CNT_W'(1);
                        if (rem_r == CNT_W'(1)) begin
                            state_nx = FIN;
                        end
                    end
                end
                FIN: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        q_nx  = q_r;
        so_nx = so_r;
        if (bus.sclr && bus.E) begin
            q_nx  = '0;
            so_nx = 1'b0;
        end else if (state == IDLE && bus.ld && bus.E) begin
            q_nx = bus.D;
        end else if (do_shift) begin
            if (shift_dir) begin
                q_nx  = q_right;
                so_nx = q_r[0];
            end else begin
                q_nx  = q_left;
                so_nx = q_r[WIDTH-1];
            end
        end
    end

    assign bus.Q    = q_r;
    assign bus.so   = so_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == FIN);
endmodule

// File: tb/tb_shreg_seq.sv
// tb/tb_shreg_seq.sv - directed self-checking bench for shreg_seq (WIDTH=4, CNT_W=3)
module tb_shreg_seq;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    shreg_seq_if #(.WIDTH(4), .CNT_W(3)) bus ();

    shreg_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] q, input logic so,
                               input logic busy, input logic done);
        check({tag, ".Q"},    32'(bus.Q),    32'(q));
        check({tag, ".so"},   32'(bus.so),   32'(so));
        check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
        check({tag, ".done"}, 32'(bus.done), 32'(done));
    endtask

    task automatic load(input logic [3:0] d);
        bus.ld = 1'b1; bus.E = 1'b1; bus.D = d; bus.start = 1'b0; bus.sclr = 1'b0;
        step();
        bus.ld = 1'b0;
        check("load.Q", 32'(bus.Q), 32'(d));
    endtask

    logic [3:0] exp_q;
    logic       exp_so;
    int         busy_cycles;

    initial begin
        reset = 1'b1;
        bus.D = '0; bus.sclr = 0; bus.ld = 0; bus.E = 0; bus.dir = 0;
        bus.w = 0; bus.start = 0; bus.cnt = '0;
`ifdef SHREG_ROTATE_EN
        bus.rot = 1'b0;
`endif
        step();
        check_state("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Load then a single idle left shift
        bus.ld = 1; bus.E = 1; bus.D = 4'b1011;
        step();
        check_state("ld1011", 4'b1011, 1'b0, 1'b0, 1'b0);
        bus.ld = 0; bus.dir = 0; bus.w = 0;
        step();
        check_state("shl", 4'b0110, 1'b1, 1'b0, 1'b0);

        // Counted right shifts, cnt=3, w=1; dir changed after start must not matter
        load(4'b1001);
        bus.start = 1; bus.cnt = 3; bus.dir = 1; bus.w = 1; bus.E = 1;
        step();
        check_state("seq3.start", 4'b1001, 1'b1, 1'b1, 1'b0);
        bus.start = 0; bus.dir = 0;
        step();
        check_state("seq3.s1", 4'b1100, 1'b1, 1'b1, 1'b0);
        step();
        check_state("seq3.s2", 4'b1110, 1'b0, 1'b1, 1'b0);
        step();
        check_state("seq3.s3", 4'b1111, 1'b0, 1'b0, 1'b1);
        step();
        check_state("seq3.after", 4'b1111, 1'b0, 1'b0, 1'b0);
        bus.E = 0;

        // cnt=0 goes straight to FIN
        bus.start = 1; bus.cnt = 0;
        step();
        check_state("cnt0", 4'b1111, 1'b0, 1'b0, 1'b1);
        bus.start = 0;
        step();
        check_state("cnt0.after", 4'b1111, 1'b0, 1'b0, 1'b0);

        // cnt=4 with a two-cycle stall mid-run
        load(4'b0101);
        bus.start = 1; bus.cnt = 4; bus.dir = 0; bus.w = 0; bus.E = 1;
        step();
        check_state("stall.start", 4'b0101, 1'b0, 1'b1, 1'b0);
        bus.start = 0;
        step();
        check_state("stall.s1", 4'b1010, 1'b0, 1'b1, 1'b0);
        step();
        check_state("stall.s2", 4'b0100, 1'b1, 1'b1, 1'b0);
        bus.E = 0; bus.w = 1;
        step();
        check_state("stall.h1", 4'b0100, 1'b1, 1'b1, 1'b0);
        step();
        check_state("stall.h2", 4'b0100, 1'b1, 1'b1, 1'b0);
        bus.E = 1;
        step();
        check_state("stall.s3", 4'b1001, 1'b0, 1'b1, 1'b0);
        step();
        check_state("stall.s4", 4'b0011, 1'b1, 1'b0, 1'b1);
        bus.E = 0;
        step();
        check_state("stall.after", 4'b0011, 1'b1, 1'b0, 1'b0);

        // cnt=5 > WIDTH, with ld/start held high during the run (must be ignored)
        load(4'b0001);
        bus.start = 1; bus.cnt = 5; bus.dir = 0; bus.w = 0; bus.E = 1;
        step();
        bus.ld = 1; bus.D = 4'b1111; bus.cnt = 0;
        exp_q = 4'b0001; exp_so = 1'b0; busy_cycles = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_so = exp_q[3];
            exp_q  = {exp_q[2:0], 1'b0};
            check($sformatf("cnt5.q%0d", i), 32'(bus.Q), 32'(exp_q));
            if (bus.busy) busy_cycles++;
        end
        check("cnt5.so", 32'(bus.so), 32'(exp_so));
        check("cnt5.busy_cycles", 32'(busy_cycles), 32'd5);
        check("cnt5.done", 32'(bus.done), 32'd1);
        bus.ld = 0; bus.start = 0; bus.E = 0;
        step();
        check_state("cnt5.after", 4'b0000, 1'b0, 1'b0, 1'b0);

        // sclr aborts a run after two shifts, no done pulse
        load(4'b1111);
        bus.start = 1; bus.cnt = 4; bus.dir = 1; bus.w = 0; bus.E = 1;
        step();
        bus.start = 0;
        step();
        check("abort.s1", 32'(bus.Q), 32'(4'b0111));
        step();
        check_state("abort.s2", 4'b0011, 1'b1, 1'b1, 1'b0);
        bus.sclr = 1;
        step();
        check_state("abort.clr", 4'b0000, 1'b0, 1'b0, 1'b0);
        bus.sclr = 0; bus.E = 0;
        step();
        check_state("abort.after", 4'b0000, 1'b0, 1'b0, 1'b0);

        // reset mid-run
        load(4'b1111);
        bus.start = 1; bus.cnt = 4; bus.dir = 1; bus.w = 0; bus.E = 1;
        step();
        bus.start = 0;
        step();
        step();
        check("rst.s2", 32'(bus.Q), 32'(4'b0011));
        reset = 1;
        step();
        check_state("rst.mid", 4'b0000, 1'b0, 1'b0, 1'b0);
        reset = 0; bus.E = 0;
        step();
        check_state("rst.after", 4'b0000, 1'b0, 1'b0, 1'b0);

`ifdef SHREG_ROTATE_EN
        load(4'b1000);
        bus.rot = 1; bus.dir = 0; bus.w = 0; bus.E = 1;
        step();
        check_state("rotl", 4'b0001, 1'b1, 1'b0, 1'b0);
        bus.rot = 1; bus.dir = 1;
        step();
        check_state("rotr", 4'b1000, 1'b1, 1'b0, 1'b0);
        bus.rot = 0; bus.E = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
